frame_crc_checker: RTL and testbench
====================================

// Module: frame_crc_checker
// PURPOSE
//  Byte-stream CRC-16 checker directly upstream of the link monitor. Delimits frames with
//  sof/eof and checks each frame's trailing CRC-16/CCITT. Emits one result pulse per frame
//  (valid + crc_fail), which drives the monitor's valid/crc_fail inputs one-for-one.
// PARAMETERS
//  MIN_FRAME_BYTES  3      min legal length incl. 2 CRC bytes; shorter -> runt (fail)
//  MAX_FRAME_BYTES  1024   max legal length incl. CRC; longer -> overlong (fail); <= 65534
//  CRC_INIT         16'hFFFF  CRC register seed at each sof
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous reset, active low
//  in_valid      in   1   byte strobe; in_data/in_sof/in_eof qualified by it
//  in_data       in   8   frame byte; payload first, then CRC MSB byte, then CRC LSB byte
//  in_sof        in   1   first byte of frame
//  in_eof        in   1   last byte of frame (CRC LSB byte)
//  valid         out  1   1-cycle pulse: frame result available
//  crc_fail      out  1   frame failed (CRC, runt, overlong or abort); meaningful when valid
//  frame_len     out  16  bytes in reported frame incl. CRC, saturating; meaningful when valid
//  err_runt      out  1   length < MIN_FRAME_BYTES; meaningful when valid
//  err_long      out  1   length > MAX_FRAME_BYTES; meaningful when valid
//  err_abort     out  1   frame terminated by new sof before eof; meaningful when valid
// BEHAVIOUR
//  Reset: state IDLE, crc_reg=CRC_INIT, len=0, all outputs 0. Async assert clears
//   everything immediately; a partial frame is discarded, no result is emitted.
//  CRC: poly 0x1021, MSB-first, no reflection, no final XOR, 8 bit-steps per byte (comb).
//   Runs over every byte incl. the two CRC bytes. Pass iff residue == 16'h0000 after eof.
//  Length: len counts accepted bytes incl. sof and eof bytes. Saturates at 16'hFFFF.
//  States:
//   IDLE:     in_valid&in_sof -> IN_FRAME, crc_reg=step(CRC_INIT,in_data), len=1.
//             in_valid&in_sof&in_eof -> 1-byte frame, report next cycle, stay IDLE.
//             in_valid & !in_sof -> byte dropped (incl. stray eof), no output.
//   IN_FRAME: in_valid&!in_sof -> crc_reg=step(crc_reg,in_data), len++.
//             ...&in_eof -> report, -> IDLE.
//             in_valid&in_sof (abort) -> report the old frame with err_abort=1 and
//              crc_fail=1, frame_len=old len. Restart on this byte (seed CRC_INIT,
//              len=1), stay IN_FRAME. If in_eof is also set, the 1-byte frame is
//              discarded unreported and the state -> IDLE.
//             in_valid low: hold all state; gaps of any length are allowed.
//  Report: registered. valid=1 for exactly the cycle after the eof/abort byte.
//   frame_len=final len. err_runt=(len<MIN_FRAME_BYTES), err_long=(len>MAX_FRAME_BYTES).
//   crc_fail = residue!=0 | err_runt | err_long | err_abort.
//   valid=0 on all other cycles. crc_fail/frame_len/err_* hold their last value when
//   valid=0. At most one report per cycle.
//  Throughput: 1 byte/cycle sustained. Back-to-back frames need no idle cycle: the byte
//   after eof may carry sof.
//  No backpressure. Input is never stalled.
// TESTING
//  1) bytes "123456789" (0x31..0x39) + 0x29,0xB1, sof on 1st, eof on last ->
//     one valid pulse the cycle after eof, crc_fail=0, frame_len=11, err_*=0.
//  2) same frame with in_data[0] of byte 3 flipped -> valid, crc_fail=1, frame_len=11, err_*=0.
//  3) sof+eof on one byte from IDLE, then 2-byte frame -> two reports:
//     len=1 and len=2, both err_runt=1, crc_fail=1.
//  4) 5 bytes without eof, then sof on new good frame from test 1 -> first report
//     err_abort=1, crc_fail=1, frame_len=5; second report pass, frame_len=11.
//  5) MAX_FRAME_BYTES=16, 20-byte frame with correct CRC -> err_long=1, crc_fail=1,
//     frame_len=20. Repeat with random in_valid gaps: same results.
//  6) assert rst_n mid-frame, release, then frame from test 1 ->
//     no report for the partial frame; clean pass for the new one.
//     Stray eof in IDLE -> no valid.

Source files
------------

// File: rtl/frame_crc_checker.sv
`default_nettype none
// ============================================================================
//  Module      : frame_crc_checker
//  Description : Byte-stream CRC-16/CCITT frame checker. Delimits frames by
//                sof/eof, checks the trailing CRC (residue must be zero) and
//                length limits, and emits one registered result pulse per
//                frame (normal end or abort by a new sof).
//  Revision    : 1.0  initial release
// ============================================================================
module frame_crc_checker #(
    parameter int          MIN_FRAME_BYTES = 3,
    parameter int          MAX_FRAME_BYTES = 1024,
    parameter logic [15:0] CRC_INIT        = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        valid,
    output logic        crc_fail,
    output logic [15:0] frame_len,
    output logic        err_runt,
    output logic        err_long,
    output logic        err_abort
);

    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_BYTES);
    localparam logic [15:0] POLY     = 16'h1021;
    localparam logic [15:0] LEN_SAT  = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] crc_reg;
    logic [15:0] len;

    // One byte of MSB-first CRC-16 (poly 0x1021, no reflection), unrolled to 8 bit-steps.
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [7:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) begin
                c = {c[14:0], 1'b0} ^ POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [15:0] crc_next;   // running CRC advanced by the current byte
    logic [15:0] crc_seed;   // CRC of the current byte from a fresh seed (sof byte)
    logic [15:0] len_inc;    // saturating length after the current byte

    assign crc_next = crc_step(crc_reg, in_data);
    assign crc_seed = crc_step(CRC_INIT, in_data);
    assign len_inc  = (len == LEN_SAT) ? LEN_SAT : len + 16'd1;

    // Report decode: which frame (if any) finishes on this byte and how it ends.
    logic        rep_fire;
    logic [15:0] rep_len;
    logic        rep_crc_bad;
    logic        rep_abort;
    logic        rep_runt;
    logic        rep_long;

    // Decide whether the current byte closes a frame and collect its result.
    always_comb begin
        rep_fire    = 1'b0;
        rep_len     = len;
        rep_crc_bad = 1'b0;
        rep_abort   = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    // Single-byte frame: sof and eof on the same byte.
                    if (in_sof && in_eof) begin
                        rep_fire    = 1'b1;
                        rep_len     = 16'd1;
                        rep_crc_bad = (crc_seed != 16'h0000);
                    end
                end
                IN_FRAME: begin
                    if (in_sof) begin
                        // New sof before eof: the old frame is reported as aborted.
                        rep_fire  = 1'b1;
                        rep_len   = len;
                        rep_abort = 1'b1;
                    end else if (in_eof) begin
                        rep_fire    = 1'b1;
                        rep_len     = len_inc;
                        rep_crc_bad = (crc_next != 16'h0000);
                    end
                end
                default: ;
            endcase
        end
        rep_runt = (rep_len < MIN_LEN);
        rep_long = (rep_len > MAX_LEN);
    end

    // Frame state machine with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            crc_reg   <= CRC_INIT;
            len       <= 16'd0;
            valid     <= 1'b0;
            crc_fail  <= 1'b0;
            frame_len <= 16'd0;
            err_runt  <= 1'b0;
            err_long  <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        // Bytes without sof (stray eof included) are dropped here.
                        if (in_sof) begin
                            crc_reg <= crc_seed;
                            len     <= 16'd1;
                            if (!in_eof) begin
                                state <= IN_FRAME;
                            end
                        end
                    end
                    IN_FRAME: begin
                        if (in_sof) begin
                            // Restart on the sof byte; a sof+eof restart byte is
                            // discarded unreported.
                            crc_reg <= crc_seed;
                            len     <= 16'd1;
                            if (in_eof) begin
                                state <= IDLE;
                            end
                        end else begin
                            crc_reg <= crc_next;
                            len     <= len_inc;
                            if (in_eof) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (rep_fire) begin
                valid     <= 1'b1;
                frame_len <= rep_len;
                err_runt  <= rep_runt;
                err_long  <= rep_long;
                err_abort <= rep_abort;
                crc_fail  <= rep_crc_bad | rep_runt | rep_long | rep_abort;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_crc_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_crc_checker
//  Description : Self-checking bench for frame_crc_checker. Frames come from a
//                vector table plus hand-written corner sequences; expected
//                reports are queued when the closing byte is driven and
//                compared when the DUT pulses valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_crc_checker;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sof = 1'b0;
    logic        in_eof = 1'b0;
    logic        valid;
    logic        crc_fail;
    logic [15:0] frame_len;
    logic        err_runt;
    logic        err_long;
    logic        err_abort;

    frame_crc_checker #(
        .MIN_FRAME_BYTES(3),
        .MAX_FRAME_BYTES(MAXB),
        .CRC_INIT(16'hFFFF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_sof(in_sof),
        .in_eof(in_eof),
        .valid(valid),
        .crc_fail(crc_fail),
        .frame_len(frame_len),
        .err_runt(err_runt),
        .err_long(err_long),
        .err_abort(err_abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int len;
        bit fail;
        bit runt;
        bit lng;
        bit abrt;
        int at;
    } exp_t;

    typedef struct {
        bit fixed;
        int npay;
        bit corrupt;
        bit gaps;
        int exp_len;
        bit exp_fail;
        bit exp_runt;
        bit exp_long;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference CRC-16/CCITT-FALSE, bitwise.
    function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[k]) begin
            c = c ^ {b[k], 8'h00};
            for (int j = 0; j < 8; j++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    // Compare each DUT report against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("report_cycle", cyc, e.at);
                chk("frame_len", int'(frame_len), e.len);
                chk("crc_fail", int'(crc_fail), int'(e.fail));
                chk("err_runt", int'(err_runt), int'(e.runt));
                chk("err_long", int'(err_long), int'(e.lng));
                chk("err_abort", int'(err_abort), int'(e.abrt));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put_byte(input logic [7:0] d, input bit s, input bit e);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        in_eof   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    // Queue an expectation for a report closed by the byte about to be driven.
    task automatic expect_now(input int len, input bit fail, input bit runt,
                              input bit lng, input bit abrt);
        exp_t e;
        e.len  = len;
        e.fail = fail;
        e.runt = runt;
        e.lng  = lng;
        e.abrt = abrt;
        e.at   = cyc + 1;
        sb.push_back(e);
    endtask

    // Drive a frame; optionally close it with eof and queue the expected report.
    task automatic send(input logic [7:0] b[$], input bit with_eof, input bit gaps,
                        input bit push, input int len, input bit fail,
                        input bit runt, input bit lng);
        for (int i = 0; i < b.size(); i++) begin
            if (gaps && i > 0) idle($urandom_range(0, 2));
            if (push && with_eof && i == b.size() - 1) expect_now(len, fail, runt, lng, 1'b0);
            put_byte(b[i], i == 0, with_eof && (i == b.size() - 1));
        end
    endtask

    function automatic void build(input bit fixed, input int npay, input bit corrupt,
                                  output logic [7:0] b[$]);
        logic [15:0] c;
        b = {};
        for (int i = 0; i < npay; i++) begin
            b.push_back(fixed ? 8'(8'h31 + i) : 8'($urandom_range(0, 255)));
        end
        c = ref_crc(b);
        b.push_back(c[15:8]);
        b.push_back(c[7:0]);
        if (corrupt) b[2][0] = ~b[2][0];
    endfunction

    vec_t tbl[8];

    initial begin
        logic [7:0] fr[$];
        logic [7:0] good[$];

        tbl[0] = '{1'b1,  9, 1'b0, 1'b0, 11, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1,  9, 1'b1, 1'b0, 11, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 14, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 15, 1'b0, 1'b0, 17, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 18, 1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 18, 1'b0, 1'b1, 20, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0,  1, 1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0,  0, 1'b0, 1'b0,  2, 1'b1, 1'b1, 1'b0};

        good = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h29, 8'hB1};

        // Reset state.
        idle(2);
        chk("reset_valid", int'(valid), 0);
        chk("reset_crc_fail", int'(crc_fail), 0);
        chk("reset_frame_len", int'(frame_len), 0);
        chk("reset_err", int'({err_runt, err_long, err_abort}), 0);
        rst_n = 1'b1;
        idle(2);

        // Known-answer frame, then the table back-to-back.
        send(good, 1'b1, 1'b0, 1'b1, 11, 1'b0, 1'b0, 1'b0);
        for (int v = 0; v < 8; v++) begin
            build(tbl[v].fixed, tbl[v].npay, tbl[v].corrupt, fr);
            send(fr, 1'b1, tbl[v].gaps, 1'b1, tbl[v].exp_len, tbl[v].exp_fail,
                 tbl[v].exp_runt, tbl[v].exp_long);
        end
        idle(3);
        chk("hold_valid_low", int'(valid), 0);
        chk("hold_frame_len", int'(frame_len), 2);
        chk("hold_err_runt", int'(err_runt), 1);

        // Single-byte frame from IDLE, then a 2-byte frame.
        expect_now(1, 1'b1, 1'b1, 1'b0, 1'b0);
        put_byte(8'h55, 1'b1, 1'b1);
        fr = {8'hA0, 8'hA1};
        send(fr, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Abort after 5 bytes, then the good frame.
        fr = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send(fr, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        expect_now(5, 1'b1, 1'b0, 1'b0, 1'b1);
        send(good, 1'b1, 1'b0, 1'b1, 11, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Abort by sof+eof: old frame reported, 1-byte frame discarded, then stray eof.
        fr = {8'h10, 8'h20, 8'h30};
        send(fr, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        expect_now(3, 1'b1, 1'b0, 1'b0, 1'b1);
        put_byte(8'h11, 1'b1, 1'b1);
        put_byte(8'h22, 1'b0, 1'b1);
        idle(3);

        // Reset mid-frame: partial frame vanishes, next frame passes cleanly.
        fr = {8'h31, 8'h32, 8'h33, 8'h34};
        send(fr, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_frame_len", int'(frame_len), 0);
        chk("async_rst_crc_fail", int'(crc_fail), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(good, 1'b1, 1'b0, 1'b1, 11, 1'b0, 1'b0, 1'b0);
        idle(2);
        put_byte(8'h00, 1'b0, 1'b1);
        idle(5);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench timed out");
        $fatal(1);
    end

endmodule
`default_nettype wire
